// File: rtl/bram_porta_requester.sv
// Port-A front end for a 2048x8 block RAM with a registered output: accepts
// read/write requests, sequences the two-stage read path and returns read data in order.

module bram_porta_requester_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          fifo_full,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] depth
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full));

    a_outstanding_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= depth);

endmodule

module bram_porta_requester #(
    parameter int RSP_DEPTH = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_clka,
    output logic              ram_cea,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    output logic              ram_ocea,
    output logic              ram_rsta,
    input  logic [DATA_W-1:0] ram_doa
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              s1_r;
    logic              s2_r;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     outstanding_nxt_s;
    logic [CW-1:0]     fifo_cnt_r;
    logic [CW-1:0]     fifo_cnt_nxt_s;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [DATA_W-1:0] fifo_mem_r [RSP_DEPTH];

    logic              req_fire_s;
    logic              rd_fire_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;

    assign req_fire_s  = req_valid & req_ready_r;
    assign rd_fire_s   = req_fire_s & ~req_we;
    assign push_s      = s2_r;
    assign pop_s       = rsp_valid_r & rsp_ready;
    assign fifo_full_s = (fifo_cnt_r == DEPTH_C);

    // The RAM sees the request in its accept cycle; enables stay low otherwise.
    assign ram_clka  = clk;
    assign ram_cea   = req_fire_s;
    assign ram_wea   = req_fire_s & req_we;
    assign ram_addra = req_addr;
    assign ram_dia   = req_wdata;
    assign ram_ocea  = s1_r;
    assign ram_rsta  = ~rst_n;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = fifo_mem_r[rd_ptr_r];

    // Outstanding reads: counted from accept until the response is popped.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({rd_fire_s, pop_s})
            2'b10:   outstanding_nxt_s = outstanding_r + 1'b1;
            2'b01:   outstanding_nxt_s = outstanding_r - 1'b1;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Response FIFO occupancy.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 1'b1;
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 1'b1;
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Control state: read tokens, counters, pointers and registered handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r          <= 1'b0;
            s2_r          <= 1'b0;
            outstanding_r <= ZERO_C;
            fifo_cnt_r    <= ZERO_C;
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
        end else begin
            s1_r          <= rd_fire_s;
            s2_r          <= s1_r;
            outstanding_r <= outstanding_nxt_s;
            fifo_cnt_r    <= fifo_cnt_nxt_s;
            req_ready_r   <= (outstanding_nxt_s < DEPTH_C);
            rsp_valid_r   <= (fifo_cnt_nxt_s != ZERO_C);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // FIFO storage has no reset; an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            fifo_mem_r[wr_ptr_r] <= ram_doa;
        end
    end

    bram_porta_requester_chk #(
        .CW (CW)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .fifo_full   (fifo_full_s),
        .outstanding (outstanding_r),
        .depth       (DEPTH_C)
    );

endmodule

// File: tb/tb_bram_porta_requester.sv
// Directed bench for bram_porta_requester with a behavioural 2048x8 RAM on port A
// and a queue scoreboard checked by an independent response monitor.

module tb_bram_porta_requester;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        ram_clka;
    logic        ram_cea;
    logic        ram_wea;
    logic [10:0] ram_addra;
    logic [7:0]  ram_dia;
    logic        ram_ocea;
    logic        ram_rsta;
    logic [7:0]  ram_doa;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    bram_porta_requester #(
        .RSP_DEPTH (4),
        .ADDR_W    (11),
        .DATA_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_clka  (ram_clka),
        .ram_cea   (ram_cea),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_ocea  (ram_ocea),
        .ram_rsta  (ram_rsta),
        .ram_doa   (ram_doa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: array latch on cea (unchanged by writes), output register on ocea.
    logic [7:0] mem [0:2047];
    logic [7:0] latch_q;
    logic [7:0] doa_q;
    always @(posedge clk) begin
        if (ram_cea) begin
            if (ram_wea) mem[ram_addra] <= ram_dia;
            else         latch_q <= mem[ram_addra];
        end
        if (ram_rsta)      doa_q <= 8'h00;
        else if (ram_ocea) doa_q <= latch_q;
    end
    assign ram_doa = doa_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshaken response is compared with the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_rsp: got %0h expected no response at %0t", rsp_rdata, $time);
            end else begin
                check("rsp_data", {24'h0, rsp_rdata}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                         input logic [7:0] expd);
        logic done;
        done = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                if (!we) exp_q.push_back(expd);
            end
            next_cycle();
        end
        req_valid = 1'b0;
        if (!done) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill(input logic [10:0] addr, input logic [7:0] expd, input int n,
                        input logic record, output int acc);
        acc = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc++;
                if (record) exp_q.push_back(expd);
            end
            next_cycle();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) next_cycle();
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (4) next_cycle();
    endtask

    int acc;
    int drops;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 11'h000;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        // Reset held for three cycles.
        repeat (2) next_cycle();
        @(negedge clk);
        check("rsta_in_reset", ram_rsta, 1'b1);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cea", ram_cea, 1'b0);
        check("rst_wea", ram_wea, 1'b0);
        check("rst_ocea", ram_ocea, 1'b0);
        check("rst_rsta", ram_rsta, 1'b0);
        next_cycle();

        // Write 0x5A to 0x000, then read it back with exact latency checks.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h000; req_wdata = 8'h5A;
        @(negedge clk);
        check("wr_cea", ram_cea, 1'b1);
        check("wr_wea", ram_wea, 1'b1);
        next_cycle();
        req_we = 1'b0;
        @(negedge clk);
        check("rd_cea", ram_cea, 1'b1);
        check("rd_wea", ram_wea, 1'b0);
        check("rd_ocea_c0", ram_ocea, 1'b0);
        exp_q.push_back(8'h5A);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_ocea_c1", ram_ocea, 1'b1);
        check("rd_valid_c1", rsp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rd_ocea_c2", ram_ocea, 1'b0);
        check("rd_valid_c2", rsp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rd_valid_c3", rsp_valid, 1'b1);
        check("rd_data_c3", rsp_rdata, 8'h5A);
        next_cycle();
        drain();

        // Fill the whole array with k[7:0], then stream 2048 back-to-back reads.
        drops = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            req_addr  = 11'(k);
            req_wdata = 8'(k);
            @(negedge clk);
            if (!req_ready) drops++;
            next_cycle();
        end
        req_we = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            req_addr = 11'(k);
            @(negedge clk);
            if (!req_ready) drops++;
            else exp_q.push_back(8'(k));
            next_cycle();
        end
        req_valid = 1'b0;
        check("stream_no_drop", drops, 32'd0);
        drain();

        // Backpressure: exactly four reads accepted while the consumer stalls.
        rsp_ready = 1'b0;
        fill(11'h005, 8'h05, 8, 1'b1, acc);
        check("bp_accepts", acc, 32'd4);
        @(negedge clk);
        check("bp_ready_low", req_ready, 1'b0);
        check("bp_valid", rsp_valid, 1'b1);
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_pop", req_ready, 1'b0);
        next_cycle();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", req_ready, 1'b1);
        next_cycle();
        drain();

        // Read-write-read to one address: old data, then new data.
        issue(1'b1, 11'h010, 8'h11, 8'h00);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h010;
        @(negedge clk);
        check("il_rd1_ready", req_ready, 1'b1);
        exp_q.push_back(8'h11);
        next_cycle();
        req_we = 1'b1; req_wdata = 8'h22;
        @(negedge clk);
        check("il_wr_ready", req_ready, 1'b1);
        next_cycle();
        req_we = 1'b0;
        @(negedge clk);
        check("il_rd2_ready", req_ready, 1'b1);
        exp_q.push_back(8'h22);
        next_cycle();
        req_valid = 1'b0;
        drain();

        // Reset while two reads are in flight and two responses are queued.
        rsp_ready = 1'b0;
        fill(11'h020, 8'h20, 4, 1'b0, acc);
        check("mr_accepts", acc, 32'd4);
        @(negedge clk);
        check("mr_fifo_nonempty", rsp_valid, 1'b1);
        check("mr_s1_inflight", ram_ocea, 1'b1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) drops++;
            next_cycle();
        end
        check("mr_no_stray", drops, 32'd0);
        rsp_ready = 1'b0;
        fill(11'h007, 8'h07, 8, 1'b1, acc);
        check("mr_outstanding_zero", acc, 32'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_porta_requester.md
# bram_porta_requester

Single-clock request/response front end that drives port A of the 2048x8 dual-port block RAM configured with a registered port-A output (REGMODE_A OUTREG, WRITEMODE_A NORMAL). It accepts CPU/bus read and write requests over a valid/ready handshake. It sequences the RAM's two-stage read path (array latch, then output register loaded by ocea) and returns read data in request order through a small response FIFO with backpressure. Port B is left to its own client.

## Interface
- RSP_DEPTH, 4: response FIFO entries and maximum reads outstanding, counted from accept to response pop; power of two, ≥2; 4 gives full read throughput.
- ADDR_W, 11: RAM word-address width.
- DATA_W, 8: RAM data width.

- clk  in  1  single clock; also drives ram_clka.
- rst_n  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata.
- rsp_rdata  out  DATA_W  read data, in request order.
- ram_clka  out  1  equals clk.
- ram_cea  out  1  port-A clock enable.
- ram_wea  out  1  port-A write enable.
- ram_addra  out  ADDR_W  port-A address.
- ram_dia  out  DATA_W  port-A write data.
- ram_ocea  out  1  output-register load enable.
- ram_rsta  out  1  output-register reset, active-high; equals ~rst_n.
- ram_doa  in  DATA_W  registered port-A read data.

## Operation
- Request handshake:
  - Accept: req_fire = req_valid & req_ready.
  - req_ready = (outstanding < RSP_DEPTH). It is registered-state only, with no combinational path from rsp_ready.
  - The same condition gates writes, so req_ready does not depend on req_we.
- Issue (combinational, same cycle as req_fire):
  - ram_cea = req_fire.
  - ram_wea = req_fire & req_we.
  - ram_addra = req_addr.
  - ram_dia = req_wdata.
  - When not firing, the RAM inputs are don't-care, but ram_cea and ram_wea are 0.
- Read pipeline: 2-bit shift register of read tokens.
  - s1 <= req_fire & ~req_we.
  - s2 <= s1.
  - ram_ocea = s1.
  - In the cycle s2 is 1, ram_doa is valid and is pushed into the FIFO.
- Writes: produce no response, take no FIFO slot, and never assert ram_ocea.
- Outstanding counter, width clog2(RSP_DEPTH+1):
  - +1 on a read accept, −1 on a response pop (rsp_valid & rsp_ready).
  - Both in the same cycle leaves it unchanged.
  - Never exceeds RSP_DEPTH, so the FIFO can never overflow. A push to a full FIFO is an assertion failure.
- Response FIFO:
  - rsp_valid = ~empty.
  - rsp_rdata = head entry, registered storage.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full, which is unreachable by the counter rule, and when it is empty (push only).
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: requests execute on the RAM in accept order. A read after a write to the same address returns the new data. A write accepted while an earlier read is in s1/s2 does not disturb that read's data (NORMAL mode).

## Timing
- Reset (rst_n low at a rising edge): after that edge:
  - s1 = s2 = 0, outstanding = 0, FIFO empty.
  - rsp_valid = 0, req_ready = 1 (since outstanding = 0 < RSP_DEPTH).
  - ram_cea = ram_wea = ram_ocea = 0.
  - ram_rsta = 1 while rst_n is low.
  - rsp_rdata holds no defined value until the first push.
- Reset mid-operation: in-flight tokens and FIFO contents are discarded, with no late push after reset deasserts.
- Read latency: read accepted in cycle c → ram_ocea = 1 in c+1 → FIFO push at the end of c+2 → rsp_valid = 1 in c+3, at the earliest.
- Write latency: the RAM is written at the end of the accept cycle.
- Throughput: with rsp_ready held at 1, one read per cycle is sustained indefinitely for RSP_DEPTH ≥ 4.
  - With RSP_DEPTH = 2, reads alternate: two accepts, then req_ready is low until a pop.
- Backpressure: with rsp_ready = 0, at most RSP_DEPTH reads are accepted. req_ready then stays 0, and it returns to 1 in the cycle after the first pop.

## Test plan
- Reset → req_ready = 1, rsp_valid = 0, ram_cea = 0, ram_ocea = 0. Reset is applied via rst_n low for 3 cycles.
- Write 0x5A to addr 0x000, then read addr 0x000 (accept cycle c) → ram_ocea = 1 in c+1; rsp_valid = 1 and rsp_rdata = 0x5A first in c+3.
- Write addr k with data k[7:0] for k = 0..2047, then 2048 back-to-back reads with rsp_ready = 1 → req_ready never drops; responses return 0x00, 0x01, … 0xFF in order, wrapping every 256.
- rsp_ready = 0, continuous read requests → exactly 4 accepted, then req_ready = 0. Raise rsp_ready for 1 cycle → one pop, and req_ready = 1 the next cycle.
- Interleave: read 0x010 (holds 0x11), write 0x010 = 0x22 in the next cycle, read 0x010 → responses 0x11, then 0x22.
- Assert rst_n low for 1 cycle while two reads are in s1/s2 and the FIFO holds 2 entries → rsp_valid = 0 from the next cycle, with no stray response afterwards; outstanding = 0.
